// File: rtl/ysyx_24080006_alu_imm.sv
// rtl/ysyx_24080006_alu_imm.sv - registered RV32E immediate decode and integer ALU
// Decodes the immediate, selects the ALU operands and registers the immediate and result for the next stage.
module ysyx_24080006_alu_imm #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   input  logic [31:0]     inst,
   input  logic [XLEN-1:0] src1,
   input  logic [XLEN-1:0] src2,
   output logic            out_valid,
   output logic [XLEN-1:0] imm_out,
   output logic [XLEN-1:0] res,
   output logic [3:0]      alu_ctrl
);

   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_REG    = 7'b0110011;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm;
   logic [XLEN-1:0] op1;
   logic [XLEN-1:0] op2;
   logic [4:0]      shamt;
   logic [XLEN-1:0] alu_res;

   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   always_comb begin
      imm = '0;
      case (opcode)
         OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM:
            imm = {{20{inst[31]}}, inst[31:20]};
         OP_STORE:
            imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         OP_BRANCH:
            imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm = {inst[31:12], 12'b0};
         OP_JAL:
            imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default:
            imm = '0;
      endcase
   end

   assign op1   = src1;
   assign op2   = (opcode == OP_IMM) ? imm : src2;
   // srai carries funct7 in imm[11:5]; only the low five bits are the shift amount
   assign shamt = op2[4:0];

   always_comb begin
      alu_ctrl = {1'b0, funct3};
      if (funct7 == 7'b0100000) begin
         if (funct3 == 3'b000 && opcode == OP_REG)
            alu_ctrl = 4'b1000;
         else if (funct3 == 3'b101 && (opcode == OP_REG || opcode == OP_IMM))
            alu_ctrl = 4'b1101;
      end
   end

   always_comb begin
      alu_res = '0;
      case (alu_ctrl)
         4'b0000: alu_res = op1 + op2;
         4'b1000: alu_res = op1 - op2;
         4'b0001: alu_res = op1 << shamt;
         4'b0010: alu_res = {{(XLEN-1){1'b0}}, ($signed(op1) < $signed(op2))};
         4'b0011: alu_res = {{(XLEN-1){1'b0}}, (op1 < op2)};
         4'b0100: alu_res = op1 ^ op2;
         4'b0101: alu_res = op1 >> shamt;
         4'b1101: alu_res = $unsigned($signed(op1) >>> shamt);
         4'b0110: alu_res = op1 | op2;
         4'b0111: alu_res = op1 & op2;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         out_valid <= 1'b0;
         imm_out   <= '0;
         res       <= '0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            imm_out <= imm;
            res     <= alu_res;
         end
      end
   end

endmodule

// File: tb/tb_ysyx_24080006_alu_imm.sv
// tb/tb_ysyx_24080006_alu_imm.sv - directed-vector bench for the registered immediate/ALU block
module tb_ysyx_24080006_alu_imm;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] inst;
   logic [31:0] src1;
   logic [31:0] src2;
   logic        out_valid;
   logic [31:0] imm_out;
   logic [31:0] res;
   logic [3:0]  alu_ctrl;

   int n_tests = 0;
   int n_fail  = 0;

   ysyx_24080006_alu_imm #(.XLEN(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .inst      (inst),
      .src1      (src1),
      .src2      (src2),
      .out_valid (out_valid),
      .imm_out   (imm_out),
      .res       (res),
      .alu_ctrl  (alu_ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // apply one op, check alu_ctrl before the edge, then step past the edge
   task automatic issue(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input logic [3:0] exp_ctrl);
      inst     = i;
      src1     = a;
      src2     = b;
      in_valid = 1'b1;
      #1;
      check({tag, "_ctrl"}, {28'd0, alu_ctrl}, {28'd0, exp_ctrl});
      @(posedge clk);
      #1;
      check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
   endtask

   initial begin
      rst      = 1'b0;
      in_valid = 1'b1;
      inst     = 32'hFFF00093;
      src1     = 32'd5;
      src2     = 32'd0;

      for (int c = 0; c < 2; c++) begin
         @(posedge clk);
         #1;
         check("rst_valid", {31'd0, out_valid}, 32'd0);
         check("rst_imm",   imm_out,            32'd0);
         check("rst_res",   res,                32'd0);
      end

      rst = 1'b1;
      #1;
      check("post_rst_valid", {31'd0, out_valid}, 32'd0);

      issue(32'hFFF00093, 32'd5, 32'd0, "addi", 4'b0000);
      check("addi_imm", imm_out, 32'hFFFFFFFF);
      check("addi_res", res,     32'h00000004);

      issue(32'h40208033, 32'd3, 32'd5, "sub", 4'b1000);
      check("sub_res", res, 32'hFFFFFFFE);

      issue(32'h00208033, 32'd3, 32'd5, "add", 4'b0000);
      check("add_res", res, 32'd8);

      issue(32'h4040D093, 32'h80000000, 32'd0, "srai", 4'b1101);
      check("srai_res", res, 32'hF8000000);

      issue(32'h0040D093, 32'h80000000, 32'd0, "srli", 4'b0101);
      check("srli_res", res, 32'h08000000);

      issue(32'h002090B3, 32'd1, 32'h21, "sll", 4'b0001);
      check("sll_res", res, 32'd2);

      issue(32'h0020A033, 32'hFFFFFFFF, 32'd1, "slt", 4'b0010);
      check("slt_res", res, 32'd1);

      issue(32'h0020B033, 32'hFFFFFFFF, 32'd1, "sltu", 4'b0011);
      check("sltu_res", res, 32'd0);

      issue(32'h12345037, 32'd0, 32'd0, "lui", 4'b0101);
      check("lui_imm", imm_out, 32'h12345000);

      issue(32'hFE112E23, 32'd0, 32'd0, "sw", 4'b0010);
      check("sw_imm", imm_out, 32'hFFFFFFFC);

      issue(32'hFE000EE3, 32'd0, 32'd0, "beq", 4'b0000);
      check("beq_imm", imm_out, 32'hFFFFFFFC);

      issue(32'h0080006F, 32'd0, 32'd0, "jal", 4'b0000);
      check("jal_imm", imm_out, 32'h00000008);

      // opcode 0: imm 0, add of 7 + 9 so res is visibly non-zero for the hold check
      issue(32'h00000000, 32'd7, 32'd9, "nop0", 4'b0000);
      check("nop0_imm", imm_out, 32'd0);
      check("nop0_res", res,     32'd16);

      in_valid = 1'b0;
      inst     = 32'hFFF00093;
      src1     = 32'h55;
      @(posedge clk);
      #1;
      check("idle_valid", {31'd0, out_valid}, 32'd0);
      check("idle_imm",   imm_out,            32'd0);
      check("idle_res",   res,                32'd16);

      // reset wins over a simultaneous valid op
      in_valid = 1'b1;
      inst     = 32'h12345037;
      rst      = 1'b0;
      @(posedge clk);
      #1;
      check("rst_pri_valid", {31'd0, out_valid}, 32'd0);
      check("rst_pri_imm",   imm_out,            32'd0);
      check("rst_pri_res",   res,                32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
